pipeline_ctrl: RTL and testbench

Central stall/flush sequencer for the 5-stage pipelined CPU. It sits beside the ID stage and replaces the scattered hazard and enable logic. It merges three inputs: load-use hazard detection, taken branch/jump flush, and a data-memory request/acknowledge handshake. From these it drives the PC, IF/ID, ID/EX and back-end pipeline-register enables, plus sticky error and performance counters.

---
 rtl/pipeline_ctrl_pkg.sv | 22 ++
 rtl/pipeline_ctrl_load_use_detect.sv | 29 ++
 rtl/pipeline_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_pipeline_ctrl.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_ctrl_pkg
// Description : Shared types and constants for the pipeline stall/flush
//               sequencer: FSM state encoding and the register-zero constant.
// Revision    : 1.0 - initial release
// ============================================================================
package pipeline_ctrl_pkg;

  // Sequencer states. Width is fixed at two bits.
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RUN      = 2'd1,
    ST_MEM_WAIT = 2'd2,
    ST_ERROR    = 2'd3
  } state_t;

  // Architectural register zero is hard-wired, so it never creates a hazard.
  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage : pipeline_ctrl_pkg
`default_nettype wire

// File: rtl/pipeline_ctrl_load_use_detect.sv
`default_nettype none
// ============================================================================
// Module      : load_use_detect
// Description : Combinational load-use hazard comparator. Flags an ID-stage
//               instruction that reads the destination of a load now in EX.
// Revision    : 1.0 - initial release
// ============================================================================
module load_use_detect
  import pipeline_ctrl_pkg::*;
(
  input  logic       idex_mem_read,
  input  logic [4:0] idex_rt,
  input  logic [4:0] ifid_rs,
  input  logic [4:0] ifid_rt,
  output logic       lu
);

  logic rt_nonzero;
  logic src_match;

  // A load into r0 is harmless; any other matching source register must wait.
  always_comb begin
    rt_nonzero = (idex_rt != REG_ZERO);
    src_match  = (idex_rt == ifid_rs) || (idex_rt == ifid_rt);
    lu         = idex_mem_read && rt_nonzero && src_match;
  end

endmodule : load_use_detect
`default_nettype wire

// File: rtl/pipeline_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_ctrl
// Description : Central stall/flush sequencer for the 5-stage CPU. Merges
//               data-memory handshake stalls, load-use bubbles and taken
//               branch/jump flushes into the pipeline-register enables, and
//               keeps a sticky timeout flag plus saturating perf counters.
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 64,
  parameter int STALL_CNT_W = 32,
  parameter int FLUSH_CNT_W = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   start_i,
  input  logic                   IDEXMemRead_i,
  input  logic [4:0]             IDEXRt_i,
  input  logic [4:0]             IFIDRs_i,
  input  logic [4:0]             IFIDRt_i,
  input  logic                   Branch_i,
  input  logic                   Jump_i,
  input  logic                   EXMEMMemRead_i,
  input  logic                   EXMEMMemWrite_i,
  input  logic                   dmem_ack_i,
  output logic                   dmem_req_o,
  output logic                   PCWrite_o,
  output logic                   IFIDWrite_o,
  output logic                   IFIDFlush_o,
  output logic                   IDEXBubble_o,
  output logic                   PipeWrite_o,
  output logic                   error_o,
  output logic [STALL_CNT_W-1:0] stall_cnt_o,
  output logic [FLUSH_CNT_W-1:0] flush_cnt_o
);

  // Wait counter only needs to reach MEM_TIMEOUT-1.
  localparam int WCNT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(MEM_TIMEOUT - 1);

  // --------------------------------------------------------------------------
  // State and registered outputs
  // --------------------------------------------------------------------------
  state_t                 state;
  state_t                 next_state;
  logic [WCNT_W-1:0]      wcnt;
  logic                   error_flag;
  logic [STALL_CNT_W-1:0] stall_cnt;
  logic [FLUSH_CNT_W-1:0] flush_cnt;

  // --------------------------------------------------------------------------
  // Combinational control
  // --------------------------------------------------------------------------
  logic lu;
  logic memop;
  logic ctl_dmem_req;
  logic ctl_pc_write;
  logic ctl_ifid_write;
  logic ctl_ifid_flush;
  logic ctl_idex_bubble;
  logic ctl_pipe_write;
  logic stall_inc;
  logic flush_inc;

  load_use_detect u_load_use_detect (
    .idex_mem_read (IDEXMemRead_i),
    .idex_rt       (IDEXRt_i),
    .ifid_rs       (IFIDRs_i),
    .ifid_rt       (IFIDRt_i),
    .lu            (lu)
  );

  assign memop = EXMEMMemRead_i | EXMEMMemWrite_i;

  // Mealy control decode: memory stall beats load-use, load-use beats flush.
  always_comb begin
    next_state      = state;
    ctl_dmem_req    = 1'b0;
    ctl_pc_write    = 1'b0;
    ctl_ifid_write  = 1'b0;
    ctl_ifid_flush  = 1'b0;
    ctl_idex_bubble = 1'b0;
    ctl_pipe_write  = 1'b0;

    case (state)
      ST_IDLE: begin
        if (start_i) begin
          next_state = ST_RUN;
        end
      end

      ST_RUN: begin
        ctl_dmem_req = memop;
        if (memop && !dmem_ack_i) begin
          // Freeze everything; the run/stop decision is taken at the ack.
          next_state = ST_MEM_WAIT;
        end else begin
          if (lu) begin
            // Hold PC and IF/ID, inject one bubble; the load moves on, so
            // the hazard clears by itself on the following cycle.
            ctl_idex_bubble = 1'b1;
            ctl_pipe_write  = 1'b1;
          end else begin
            ctl_pc_write   = 1'b1;
            ctl_ifid_write = 1'b1;
            ctl_pipe_write = 1'b1;
            ctl_ifid_flush = Branch_i | Jump_i;
          end
          if (!start_i) begin
            next_state = ST_IDLE;
          end
        end
      end

      ST_MEM_WAIT: begin
        ctl_dmem_req = 1'b1;
        if (dmem_ack_i) begin
          // The access completes this cycle, so the pipe may advance now.
          ctl_pc_write   = 1'b1;
          ctl_ifid_write = 1'b1;
          ctl_pipe_write = 1'b1;
          next_state     = start_i ? ST_RUN : ST_IDLE;
        end else if (wcnt == WCNT_LAST) begin
          next_state = ST_ERROR;
        end
      end

      ST_ERROR: begin
        // Terminal until reset: request dropped, pipe frozen.
        next_state = ST_ERROR;
      end

      default: begin
        next_state = ST_IDLE;
      end
    endcase
  end

  // Perf-counter increment conditions derived from the decoded controls.
  always_comb begin
    stall_inc = ((state == ST_RUN) || (state == ST_MEM_WAIT)) && !ctl_pc_write;
    flush_inc = ctl_ifid_flush;
  end

  // FSM state, memory wait counter and sticky timeout flag.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= ST_IDLE;
      wcnt       <= '0;
      error_flag <= 1'b0;
    end else begin
      state <= next_state;
      if ((state == ST_MEM_WAIT) && !dmem_ack_i && (wcnt != WCNT_LAST)) begin
        wcnt <= wcnt + 1'b1;
      end else begin
        wcnt <= '0;
      end
      if (next_state == ST_ERROR) begin
        error_flag <= 1'b1;
      end
    end
  end

  // Saturating stall and flush counters; they stick at all-ones.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_inc && (stall_cnt != {STALL_CNT_W{1'b1}})) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
      if (flush_inc && (flush_cnt != {FLUSH_CNT_W{1'b1}})) begin
        flush_cnt <= flush_cnt + 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Output drive
  // --------------------------------------------------------------------------
  assign dmem_req_o   = ctl_dmem_req;
  assign PCWrite_o    = ctl_pc_write;
  assign IFIDWrite_o  = ctl_ifid_write;
  assign IFIDFlush_o  = ctl_ifid_flush;
  assign IDEXBubble_o = ctl_idex_bubble;
  assign PipeWrite_o  = ctl_pipe_write;
  assign error_o      = error_flag;
  assign stall_cnt_o  = stall_cnt;
  assign flush_cnt_o  = flush_cnt;

endmodule : pipeline_ctrl
`default_nettype wire

// File: tb/tb_pipeline_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipeline_ctrl
// Description : Directed self-checking bench for pipeline_ctrl. Each step
//               pushes its expected outputs to a scoreboard queue, which is
//               popped and compared in the middle of the cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_ctrl;

  localparam int SW = 32;
  localparam int FW = 2;

  // Control vector: {req, pc, ifid, flush, bubble, pipe, err}
  localparam logic [6:0] C_IDLE = 7'b0000000;
  localparam logic [6:0] C_RUN  = 7'b0110010;
  localparam logic [6:0] C_LU   = 7'b0000110;
  localparam logic [6:0] C_FL   = 7'b0111010;
  localparam logic [6:0] C_MST  = 7'b1000000;
  localparam logic [6:0] C_MACK = 7'b1110010;
  localparam logic [6:0] C_ERR  = 7'b0000001;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          idex_mr;
  logic [4:0]    idex_rt;
  logic [4:0]    ifid_rs;
  logic [4:0]    ifid_rt;
  logic          branch;
  logic          jump;
  logic          exmem_mr;
  logic          exmem_mw;
  logic          ack;
  logic          dmem_req;
  logic          pc_write;
  logic          ifid_write;
  logic          ifid_flush;
  logic          idex_bubble;
  logic          pipe_write;
  logic          error;
  logic [SW-1:0] stall_cnt;
  logic [FW-1:0] flush_cnt;
  logic [6:0]    ctl;

  always #5 clk = ~clk;

  pipeline_ctrl #(
    .MEM_TIMEOUT (4),
    .STALL_CNT_W (SW),
    .FLUSH_CNT_W (FW)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .start_i         (start),
    .IDEXMemRead_i   (idex_mr),
    .IDEXRt_i        (idex_rt),
    .IFIDRs_i        (ifid_rs),
    .IFIDRt_i        (ifid_rt),
    .Branch_i        (branch),
    .Jump_i          (jump),
    .EXMEMMemRead_i  (exmem_mr),
    .EXMEMMemWrite_i (exmem_mw),
    .dmem_ack_i      (ack),
    .dmem_req_o      (dmem_req),
    .PCWrite_o       (pc_write),
    .IFIDWrite_o     (ifid_write),
    .IFIDFlush_o     (ifid_flush),
    .IDEXBubble_o    (idex_bubble),
    .PipeWrite_o     (pipe_write),
    .error_o         (error),
    .stall_cnt_o     (stall_cnt),
    .flush_cnt_o     (flush_cnt)
  );

  assign ctl = {dmem_req, pc_write, ifid_write, ifid_flush, idex_bubble, pipe_write, error};

  typedef struct {
    string         tag;
    logic [6:0]    ctl;
    logic [SW-1:0] stall;
    logic [FW-1:0] flush;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic set_in(input logic st, input logic mrd, input logic [4:0] xrt,
                        input logic [4:0] rs, input logic [4:0] rt,
                        input logic br, input logic jp, input logic mr,
                        input logic mw, input logic ak);
    start    = st;
    idex_mr  = mrd;
    idex_rt  = xrt;
    ifid_rs  = rs;
    ifid_rt  = rt;
    branch   = br;
    jump     = jp;
    exmem_mr = mr;
    exmem_mw = mw;
    ack      = ak;
  endtask

  task automatic push(input string tag, input logic [6:0] c, input int s, input int f);
    exp_t e;
    e.tag   = tag;
    e.ctl   = c;
    e.stall = SW'(s);
    e.flush = FW'(f);
    exp_q.push_back(e);
  endtask

  task automatic compare();
    exp_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard_empty observed none expected entry");
    end else begin
      e = exp_q.pop_front();
      checks++;
      assert (ctl === e.ctl) else begin
        errors++;
        $error("FAIL %s ctl observed %b expected %b", e.tag, ctl, e.ctl);
      end
      checks++;
      assert (stall_cnt === e.stall) else begin
        errors++;
        $error("FAIL %s stall_cnt observed %0d expected %0d", e.tag, stall_cnt, e.stall);
      end
      checks++;
      assert (flush_cnt === e.flush) else begin
        errors++;
        $error("FAIL %s flush_cnt observed %0d expected %0d", e.tag, flush_cnt, e.flush);
      end
    end
  endtask

  // Inputs are already set at posedge+1; sample at posedge+4, then advance.
  task automatic step(input string tag, input logic [6:0] c, input int s, input int f);
    push(tag, c, s, f);
    #3;
    compare();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    set_in(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state and IDLE -> RUN
    step("reset", C_IDLE, 0, 0);
    set_in(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0);
    step("idle_start", C_IDLE, 0, 0);
    step("run_plain", C_RUN, 0, 0);

    // Load-use bubble for exactly one cycle, then r0 load is harmless
    set_in(1, 1, 5'd5, 5'd5, 5'd2, 0, 0, 0, 0, 0);
    step("lu_rs", C_LU, 0, 0);
    set_in(1, 0, 5'd5, 5'd5, 5'd2, 0, 0, 0, 0, 0);
    step("lu_clear", C_RUN, 1, 0);
    set_in(1, 1, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0);
    step("lu_r0", C_RUN, 1, 0);

    // Branch with load-use: stall first, flush next cycle; then a jump
    set_in(1, 1, 5'd7, 5'd3, 5'd7, 1, 0, 0, 0, 0);
    step("lu_branch", C_LU, 1, 0);
    set_in(1, 0, 5'd7, 5'd3, 5'd7, 1, 0, 0, 0, 0);
    step("branch", C_FL, 2, 0);
    set_in(1, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0, 0, 0);
    step("jump", C_FL, 2, 1);

    // Memory read with ack three cycles later
    set_in(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, 0);
    step("mem_stall", C_MST, 2, 2);
    step("mem_wait1", C_MST, 3, 2);
    step("mem_wait2", C_MST, 4, 2);
    set_in(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, 1);
    step("mem_ack", C_MACK, 5, 2);
    set_in(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0);
    step("back_run", C_RUN, 5, 2);
    set_in(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 1);
    step("stray_ack", C_RUN, 5, 2);
    set_in(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 1);
    step("write_same_ack", C_MACK, 5, 2);

    // Flush counter saturates at 3
    set_in(1, 0, 5'd0, 5'd0, 5'd0, 1, 0, 0, 0, 0);
    step("flush3", C_FL, 5, 2);
    step("flush4", C_FL, 5, 3);
    step("flush5", C_FL, 5, 3);
    set_in(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0);
    step("flush_sat", C_RUN, 5, 3);

    // Stop requested while a memory stall begins: wait, then go IDLE
    set_in(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, 0);
    step("stop_mem", C_MST, 5, 3);
    set_in(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, 1);
    step("stop_ack", C_MACK, 6, 3);
    set_in(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0);
    step("stop_idle", C_IDLE, 6, 3);

    // Timeout: four MEM_WAIT cycles without ack, then sticky ERROR
    set_in(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0);
    step("restart", C_IDLE, 6, 3);
    set_in(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, 0);
    step("to_stall", C_MST, 6, 3);
    step("to_wait0", C_MST, 7, 3);
    step("to_wait1", C_MST, 8, 3);
    step("to_wait2", C_MST, 9, 3);
    step("to_wait3", C_MST, 10, 3);
    step("error", C_ERR, 11, 3);
    set_in(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, 1);
    step("error_late_ack", C_ERR, 11, 3);
    rst = 1'b1;
    step("error_in_rst", C_ERR, 11, 3);
    rst = 1'b0;
    set_in(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 1);
    step("post_rst", C_IDLE, 0, 0);
    step("idle_ack", C_IDLE, 0, 0);

    // Reset during MEM_WAIT drops the request; late ack ignored in IDLE
    set_in(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0);
    step("start2", C_IDLE, 0, 0);
    set_in(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, 0);
    step("stall2", C_MST, 0, 0);
    rst = 1'b1;
    step("wait_in_rst", C_MST, 1, 0);
    rst = 1'b0;
    set_in(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, 1);
    step("rst_wait_idle", C_IDLE, 0, 0);
    step("rst_wait_ack", C_IDLE, 0, 0);

    checks++;
    assert (exp_q.size() == 0) else begin
      errors++;
      $error("FAIL scoreboard_drain observed %0d expected 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule : tb_pipeline_ctrl
`default_nettype wire
